// File: rtl/mem_access_unit_if.sv
// Data-memory port between the MEM-stage access unit and the memory.
//   master (access unit): drives read, write, addr, wdata, byte_enable;
//                         samples resp, rdata
//   slave  (memory):      samples the request; drives resp (one-cycle
//                         completion pulse) and rdata (valid with resp)
interface mem_access_unit_if #(
    parameter int XLEN = 32
) ();
    localparam int NBYTE = XLEN / 8;

    logic             read;
    logic             write;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  wdata;
    logic [NBYTE-1:0] byte_enable;
    logic             resp;
    logic [XLEN-1:0]  rdata;

    modport master (
        output read, write, addr, wdata, byte_enable,
        input  resp, rdata
    );

    modport slave (
        input  read, write, addr, wdata, byte_enable,
        output resp, rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: issues handshaked data-memory requests, aligns
// byte lanes, extends load data, flags misaligned/illegal accesses,
// stalls/flushes the pipeline and forwards WB data into store data.
//   clk, rst_n          clock and async active-low reset
//   mem_valid..funct3   MEM-stage instruction decode
//   alu_out, rs2_out    effective address and store data
//   rs2, wb_rd, wb_in,
//   wb_writeback        WB->MEM store-data forwarding inputs
//   cmp_out, u_imm, pc,
//   regfilemux_sel      forward_out source selection
//   advance, flush      pipeline control
//   dmem                data-memory port (master side)
//   load_data           extended load result (held until next load)
//   mem_stall           hold upstream stages
//   access_err          misaligned or illegal access (IDLE only)
//   forward_out         MEM-stage forwarding value
//
// state | meaning
// IDLE  | no access outstanding, waiting for a memory op
// REQ   | request on the bus, waiting for dmem.resp
// DONE  | access complete, waiting for advance
module mem_access_unit #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_valid,
    input  logic                is_load,
    input  logic                is_store,
    input  logic [2:0]          funct3,
    input  logic [XLEN-1:0]     alu_out,
    input  logic [XLEN-1:0]     rs2_out,
    input  logic [4:0]          rs2,
    input  logic [4:0]          wb_rd,
    input  logic [XLEN-1:0]     wb_in,
    input  logic                wb_writeback,
    input  logic                cmp_out,
    input  logic [XLEN-1:0]     u_imm,
    input  logic [XLEN-1:0]     pc,
    input  logic [2:0]          regfilemux_sel,
    input  logic                advance,
    input  logic                flush,
    mem_access_unit_if.master   dmem,
    output logic [XLEN-1:0]     load_data,
    output logic                mem_stall,
    output logic                access_err,
    output logic [XLEN-1:0]     forward_out
);
    localparam int NBYTE = XLEN / 8;
    localparam int OFFW  = $clog2(NBYTE);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t           state;
    logic             drop;
    logic [2:0]       funct3_q;
    logic             load_q;
    logic [OFFW-1:0]  off_q;

    logic             mem_op;
    logic [OFFW-1:0]  off;
    logic             illegal;
    logic             misaligned;
    logic [7:0]       size_mask;
    logic [NBYTE-1:0] be_c;
    logic             fwd;
    logic [XLEN-1:0]  store_src;
    logic [XLEN-1:0]  wdata_c;
    logic [XLEN-1:0]  rdata_sh;
    logic [XLEN-1:0]  load_ext;

    assign mem_op    = mem_valid & (is_load | is_store);
    assign off       = alu_out[OFFW-1:0];
    assign fwd       = wb_writeback & (wb_rd == rs2) & (rs2 != 5'd0);
    assign store_src = fwd ? wb_in : rs2_out;
    assign wdata_c   = store_src << {off, 3'b000};
    assign be_c      = NBYTE'(size_mask) << off;
    // Extension uses the offset/size latched at launch, not the live inputs.
    assign rdata_sh  = dmem.rdata >> {off_q, 3'b000};

    always_comb begin
        illegal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b011:                 illegal = (XLEN == 32);
            3'b100, 3'b101:         illegal = ~is_load;
            3'b110:                 illegal = ~is_load | (XLEN == 32);
            default:                illegal = 1'b1;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        size_mask  = 8'h01;
        case (funct3[1:0])
            2'd1: begin misaligned = alu_out[0];    size_mask = 8'h03; end
            2'd2: begin misaligned = |alu_out[1:0]; size_mask = 8'h0F; end
            2'd3: begin misaligned = |alu_out[2:0]; size_mask = 8'hFF; end
            default: begin misaligned = 1'b0;       size_mask = 8'h01; end
        endcase
    end

    assign access_err = mem_op & ~flush & (state == IDLE) & (illegal | misaligned);
    assign mem_stall  = (mem_op & ~flush & ~access_err & (state != DONE)) | (state == REQ);

    always_comb begin
        load_ext = rdata_sh;
        case (funct3_q)
            3'b000: load_ext = {{(XLEN-7){rdata_sh[7]}},   rdata_sh[6:0]};
            3'b001: load_ext = {{(XLEN-15){rdata_sh[15]}}, rdata_sh[14:0]};
            3'b010: load_ext = {{(XLEN-31){rdata_sh[31]}}, rdata_sh[30:0]};
            3'b100: load_ext = XLEN'(rdata_sh[7:0]);
            3'b101: load_ext = XLEN'(rdata_sh[15:0]);
            3'b110: load_ext = XLEN'(rdata_sh[31:0]);
            default: load_ext = rdata_sh;
        endcase
    end

    always_comb begin
        forward_out = '0;
        case (regfilemux_sel)
            3'd0: forward_out = alu_out;
            3'd1: forward_out = XLEN'(cmp_out);
            3'd2: forward_out = u_imm;
            3'd3: forward_out = load_data;
            3'd4: forward_out = pc + XLEN'(4);
            default: forward_out = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            drop             <= 1'b0;
            funct3_q         <= 3'b000;
            load_q           <= 1'b0;
            off_q            <= '0;
            load_data        <= '0;
            dmem.read        <= 1'b0;
            dmem.write       <= 1'b0;
            dmem.addr        <= '0;
            dmem.wdata       <= '0;
            dmem.byte_enable <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op & ~flush & ~access_err) begin
                        dmem.read        <= is_load;
                        dmem.write       <= ~is_load;
                        dmem.addr        <= alu_out & ~XLEN'(NBYTE - 1);
                        dmem.wdata       <= wdata_c;
                        dmem.byte_enable <= be_c;
                        funct3_q         <= funct3;
                        load_q           <= is_load;
                        off_q            <= off;
                        drop             <= 1'b0;
                        state            <= REQ;
                    end
                end
                REQ: begin
                    // A flush cannot abort the bus cycle; it only discards
                    // the result once the memory has answered.
                    if (flush) drop <= 1'b1;
                    if (dmem.resp) begin
                        dmem.read  <= 1'b0;
                        dmem.write <= 1'b0;
                        drop       <= 1'b0;
                        if (load_q & ~(drop | flush)) load_data <= load_ext;
                        state <= (drop | flush) ? IDLE : DONE;
                    end
                end
                DONE: begin
                    if (advance | flush) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid, is_load, is_store, wb_writeback, cmp_out;
    logic        advance, flush;
    logic [2:0]  funct3, regfilemux_sel;
    logic [31:0] alu_out, rs2_out, wb_in, u_imm, pc;
    logic [4:0]  rs2, wb_rd;
    logic [31:0] load_data, forward_out;
    logic        mem_stall, access_err;

    mem_access_unit_if #(.XLEN(32)) dmem ();

    mem_access_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .is_load(is_load),
        .is_store(is_store), .funct3(funct3), .alu_out(alu_out), .rs2_out(rs2_out),
        .rs2(rs2), .wb_rd(wb_rd), .wb_in(wb_in), .wb_writeback(wb_writeback),
        .cmp_out(cmp_out), .u_imm(u_imm), .pc(pc), .regfilemux_sel(regfilemux_sel),
        .advance(advance), .flush(flush), .dmem(dmem), .load_data(load_data),
        .mem_stall(mem_stall), .access_err(access_err), .forward_out(forward_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_t;

    bus_t        bq[$];
    logic [31:0] lq[$];
    logic [31:0] last_load;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // Scoreboard monitor: every completed bus cycle pops an expected
    // transaction; a completed read also pops the expected load_data,
    // compared the cycle after the response.
    bit load_pending = 0;
    always @(negedge clk) begin
        if (load_pending) begin
            load_pending = 0;
            if (lq.size() == 0) check("load_q_underflow", 32'd1, 32'd0);
            else check("load_data", load_data, lq.pop_front());
        end
        if (dmem.resp && (dmem.read || dmem.write)) begin
            if (bq.size() == 0) check("bus_q_underflow", 32'd1, 32'd0);
            else begin
                bus_t e;
                e = bq.pop_front();
                check("bus_write", {31'd0, dmem.write}, {31'd0, e.wr});
                check("bus_read", {31'd0, dmem.read}, {31'd0, ~e.wr});
                check("bus_addr", dmem.addr, e.addr);
                check("bus_be", {28'd0, dmem.byte_enable}, {28'd0, e.be});
                if (e.wr) check("bus_wdata", dmem.wdata & lane_mask(e.be), e.wdata & lane_mask(e.be));
            end
            if (dmem.read) load_pending = 1;
        end
    end

    task automatic expect_load(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] val);
        bq.push_back({1'b0, addr, 32'd0, be});
        lq.push_back(val);
    endtask

    // Called just after a rising edge; returns after the op has finished.
    task automatic do_op(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input int waits, input int flush_cyc,
                         input bit adv, output int stalls, output int reqs, output logic err);
        int  cnt;
        bit  fin;
        mem_valid = 1; is_load = ld; is_store = ~ld; funct3 = f3;
        alu_out = addr; rs2_out = data; dmem.rdata = data; flush = 0; advance = 0;
        cnt = 0; stalls = 0; reqs = 0; err = 0; fin = 0;
        for (int c = 0; c < 40 && !fin; c++) begin
            @(negedge clk);
            if (c == 0) err = access_err;
            if (mem_stall) stalls++;
            if (dmem.read || dmem.write) reqs++;
            if (!mem_stall) fin = 1;
            else begin
                @(posedge clk); #1;
                flush = (c == flush_cyc);
                if (flush) mem_valid = 0;
                if (dmem.read || dmem.write) begin
                    dmem.resp = (cnt == waits);
                    cnt++;
                end else dmem.resp = 0;
            end
        end
        check("op_completed", {31'd0, fin}, 32'd1);
        @(posedge clk); #1;
        mem_valid = 0; flush = 0; dmem.resp = 0; advance = adv;
        @(posedge clk); #1;
        advance = 0;
    endtask

    int   st, rq;
    logic er;

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] pcv;
        logic [31:0] exp;
    } fwd_t;
    fwd_t fwd_tab[7];

    initial begin
        rst_n = 0; mem_valid = 0; is_load = 0; is_store = 0; funct3 = 0;
        alu_out = 0; rs2_out = 0; rs2 = 0; wb_rd = 0; wb_in = 0; wb_writeback = 0;
        cmp_out = 0; u_imm = 0; pc = 0; regfilemux_sel = 0; advance = 0; flush = 0;
        dmem.resp = 0; dmem.rdata = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("rst_read", {31'd0, dmem.read}, 32'd0);
        check("rst_write", {31'd0, dmem.write}, 32'd0);
        check("rst_addr", dmem.addr, 32'd0);
        check("rst_wdata", dmem.wdata, 32'd0);
        check("rst_be", {28'd0, dmem.byte_enable}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_stall", {31'd0, mem_stall}, 32'd0);
        @(posedge clk); #1;

        // SW with three wait cycles
        bq.push_back({1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF});
        do_op(1'b0, 3'b010, 32'h1004, 32'hDEAD_BEEF, 3, -1, 1'b1, st, rq, er);
        check("sw_stall_cycles", st, 5);
        check("sw_write_cycles", rq, 4);
        check("sw_err", {31'd0, er}, 32'd0);

        // LB / LBU / LH / LW from the same word
        expect_load(32'h2000, 4'h8, 32'hFFFF_FF80);
        do_op(1'b1, 3'b000, 32'h2003, 32'h80FF_0000, 0, -1, 1'b1, st, rq, er);
        check("lb_stall_cycles", st, 2);
        check("lb_read_cycles", rq, 1);
        expect_load(32'h2000, 4'h8, 32'h0000_0080);
        do_op(1'b1, 3'b100, 32'h2003, 32'h80FF_0000, 0, -1, 1'b1, st, rq, er);
        expect_load(32'h2000, 4'hC, 32'hFFFF_80FF);
        do_op(1'b1, 3'b001, 32'h2002, 32'h80FF_0000, 1, -1, 1'b1, st, rq, er);
        check("lh_stall_cycles", st, 3);
        expect_load(32'h2000, 4'hF, 32'h1234_5678);
        do_op(1'b1, 3'b010, 32'h2000, 32'h1234_5678, 0, -1, 1'b1, st, rq, er);
        last_load = 32'h1234_5678;

        // SH with WB forwarding, then with x0 (no forwarding), then SB lane 3
        rs2 = 5; wb_rd = 5; wb_writeback = 1; wb_in = 32'h1234_ABCD;
        bq.push_back({1'b1, 32'h0000_0010, 32'h1234_ABCD, 4'h3});
        do_op(1'b0, 3'b001, 32'h10, 32'h5555_6666, 0, -1, 1'b1, st, rq, er);
        rs2 = 0; wb_rd = 0;
        bq.push_back({1'b1, 32'h0000_0010, 32'h5555_6666, 4'h3});
        do_op(1'b0, 3'b001, 32'h10, 32'h5555_6666, 0, -1, 1'b1, st, rq, er);
        rs2 = 7; wb_rd = 6;
        bq.push_back({1'b1, 32'h0000_0010, 32'hDD00_0000, 4'h8});
        do_op(1'b0, 3'b000, 32'h13, 32'hAABB_CCDD, 0, -1, 1'b1, st, rq, er);
        rs2 = 0; wb_rd = 0; wb_writeback = 0;

        // Misaligned LW and illegal LD / LWU on a 32-bit datapath
        do_op(1'b1, 3'b010, 32'h3002, 32'h0, 0, -1, 1'b1, st, rq, er);
        check("lw_mis_err", {31'd0, er}, 32'd1);
        check("lw_mis_stall", st, 0);
        check("lw_mis_read", rq, 0);
        do_op(1'b1, 3'b011, 32'h1000, 32'h0, 0, -1, 1'b1, st, rq, er);
        check("ld32_err", {31'd0, er}, 32'd1);
        check("ld32_stall", st, 0);
        do_op(1'b1, 3'b110, 32'h1000, 32'h0, 0, -1, 1'b1, st, rq, er);
        check("lwu32_err", {31'd0, er}, 32'd1);

        // Flush during REQ: bus cycle completes, result dropped, no DONE
        expect_load(32'h4000, 4'hF, last_load);
        do_op(1'b1, 3'b010, 32'h4000, 32'hCAFE_F00D, 2, 0, 1'b0, st, rq, er);
        check("drop_stall_cycles", st, 4);
        check("drop_read_cycles", rq, 3);
        // No advance given: this op only issues if the unit returned to IDLE
        expect_load(32'h4004, 4'hF, 32'h8765_4321);
        do_op(1'b1, 3'b010, 32'h4004, 32'h8765_4321, 0, -1, 1'b1, st, rq, er);
        check("after_drop_stall", st, 2);
        check("after_drop_read", rq, 1);
        regfilemux_sel = 3;
        #1 check("fwd_load_data", forward_out, 32'h8765_4321);

        // Reset while a load is outstanding
        mem_valid = 1; is_load = 1; is_store = 0; funct3 = 3'b010; alu_out = 32'h5000;
        @(posedge clk); #1;
        check("pre_rst_read", {31'd0, dmem.read}, 32'd1);
        mem_valid = 0;
        #2 rst_n = 0;
        #1;
        check("rst_mid_read", {31'd0, dmem.read}, 32'd0);
        check("rst_mid_addr", dmem.addr, 32'd0);
        check("rst_mid_stall", {31'd0, mem_stall}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1; dmem.resp = 1; dmem.rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem.resp = 0;
        @(negedge clk);
        check("stray_resp_load", load_data, 32'd0);
        check("stray_resp_stall", {31'd0, mem_stall}, 32'd0);
        check("stray_resp_read", {31'd0, dmem.read}, 32'd0);

        // Forwarding mux
        alu_out = 32'h1111_2222; cmp_out = 1; u_imm = 32'hABCD_E000;
        fwd_tab[0] = {3'd0, 32'hFFFF_FFFC, 32'h1111_2222};
        fwd_tab[1] = {3'd1, 32'hFFFF_FFFC, 32'h0000_0001};
        fwd_tab[2] = {3'd2, 32'hFFFF_FFFC, 32'hABCD_E000};
        fwd_tab[3] = {3'd3, 32'hFFFF_FFFC, 32'h0000_0000};
        fwd_tab[4] = {3'd4, 32'hFFFF_FFFC, 32'h0000_0000};
        fwd_tab[5] = {3'd4, 32'h0000_0100, 32'h0000_0104};
        fwd_tab[6] = {3'd6, 32'h0000_0100, 32'h0000_0000};
        for (int i = 0; i < 7; i++) begin
            regfilemux_sel = fwd_tab[i].sel;
            pc = fwd_tab[i].pcv;
            #1 check($sformatf("fwd_sel%0d_%0d", fwd_tab[i].sel, i), forward_out, fwd_tab[i].exp);
        end

        repeat (2) @(posedge clk);
        check("bus_q_empty", bq.size(), 0);
        check("load_q_empty", lq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
